// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t        : converter FSM states
//   DIGIT_W        : width of one BCD digit
//   BCD_CNT_W      : iteration-counter width for the default 8-bit operand
//   bcd_cnt_width(): iteration-counter width for an arbitrary operand width n
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int DIGIT_W       = 4;
    localparam int BCD_N_DEFAULT = 8;
    localparam int BCD_CNT_W     = $clog2(BCD_N_DEFAULT + 1);

    // Counter must hold the value n itself, hence n+1 codes.
    function automatic int bcd_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble correction cell: digits of 5 or more get +3 so
// that the following left shift carries correctly into the next decade.
// Ports:
//   i_digit : pre-shift BCD digit
//   o_digit : corrected digit (at most 4'd12, so 4 bits never overflow)
// -----------------------------------------------------------------------------
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    always_comb begin
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Iterative shift-and-add-3 binary-to-BCD converter, one operand bit per clock,
// with a start/busy/done handshake. Feeds the 7-segment decoders from the
// accumulator sum.
//
// Optional build macro: BIN_TO_BCD_SIGNED_EN
//   defined   : bin is two's complement; the magnitude is converted and neg
//               reports the sign of the last result.
//   undefined : bin is unsigned; neg is tied to 0.
//
// Parameters:
//   N      : operand width
//   DIGITS : BCD output digits (10**DIGITS must exceed 2**N - 1)
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   start  : conversion request, only sampled while idle
//   bin    : operand, captured on the accepting edge
//   busy   : conversion in progress
//   done   : one-cycle completion pulse
//   bcd    : result, units digit in [3:0]; held until the next completion
//   neg    : sign of the last result
//
// States:
//   IDLE | waiting for start, busy=0
//   CONV | shifting one bit per clock, counter runs N down to 1
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 3
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N-1:0]              bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      neg
);

    localparam int CNT_W = bcd_cnt_width(N);
    localparam int BCD_W = DIGIT_W * DIGITS;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_done;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [N-1:0]       w_mag;
    logic [BCD_W-1:0]   w_corr;
    logic [BCD_W+N-1:0] w_cat;
    logic [BCD_W+N-1:0] w_cat_sh;

    // Corrections are applied to all digits in parallel from the pre-shift
    // scratch value.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
                .o_digit (w_corr[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    assign w_cat    = {w_corr, r_shift};
    assign w_cat_sh = w_cat << 1;

`ifdef BIN_TO_BCD_SIGNED_EN
    logic r_neg_pend;
    logic r_neg;

    // Unsigned negate: the most negative code maps to its own bit pattern,
    // which read as unsigned is the correct magnitude (0x80 -> 128).
    assign w_mag = bin[N-1] ? (N'(0) - bin) : bin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg_pend <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            if (w_load) begin
                r_neg_pend <= bin[N-1];
            end
            if (w_last) begin
                r_neg <= r_neg_pend;
            end
        end
    end

    assign neg = r_neg;
`else
    assign w_mag = bin;
    assign neg   = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state and datapath controls
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: shift register, scratch digits, counter and result latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_shift   <= w_mag;
                r_scratch <= '0;
                r_cnt     <= CNT_W'(N);
            end else if (w_step) begin
                r_scratch <= w_cat_sh[BCD_W+N-1:N];
                r_shift   <= w_cat_sh[N-1:0];
                r_cnt     <= r_cnt - CNT_W'(1);
                // Result register only sees the finished value.
                if (w_last) begin
                    r_bcd <= w_cat_sh[BCD_W+N-1:N];
                end
            end
        end
    end

    assign busy = (r_state == CONV);
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter sitting directly downstream of the N-bit accumulator on the board: it takes the accumulator sum and produces decimal digits for the 7-segment hex decoders. It uses iterative shift-and-add-3 (double dabble), one bit per clock, with a start/busy/done handshake. The board top pulses `start` whenever the accumulator register updates.

## Interface
Parameters:
- `N`, 8, input width in bits
- `DIGITS`, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^N − 1

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  request conversion of `bin`; sampled only when `busy`=0
- `bin`  in  N  binary operand, captured on the accepting edge
- `busy`  out  1  conversion in progress
- `done`  out  1  one-cycle pulse; `bcd` and `neg` are valid from this cycle on
- `bcd`  out  4*DIGITS  result; digit 0 (units) in bits [3:0]
- `neg`  out  1  sign of the last result (see Configuration)

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - CONV: `busy`=1, iteration counter counts N down to 1.
- IDLE with `start`=1: capture the operand into the shift register, clear the scratch digits, load counter=N, go to CONV.
- IDLE with `start`=0: stay in IDLE.
- Each CONV cycle:
  - Every scratch digit ≥5 gets +3, all digits in parallel, using the pre-shift values.
  - Then {scratch, shift} shifts left by 1 and the counter decrements.
- Last CONV iteration (counter=1):
  - Load `bcd` from the final scratch value.
  - Assert `done` for one cycle and return to IDLE.
- `start` while `busy`=1 is ignored. There is no queueing.
- `bcd`/`neg` hold their value until the next completion. A partial result is never visible on the outputs.
- Digit arithmetic is 4-bit and unsigned. The correction never exceeds 4'd12 before the shift.

## Timing
- Start accepted at edge k → `busy`=1 after edge k.
- CONV occupies edges k+1 … k+N.
- After edge k+N: `done`=1, `busy`=0, `bcd` updated. Latency is N cycles from the accepting edge to `done`.
- Back-to-back operation: `start`=1 in the `done` cycle is accepted, because `busy`=0. Throughput is one result per N+1 cycles.
- Reset values: `busy`=0, `done`=0, `bcd`=0, `neg`=0, state IDLE, counter 0.
- Reset mid-conversion: the conversion is aborted, `bcd` cleared, and no `done` is produced.
- Reset and `start` in the same cycle: reset wins, and `start` is lost.

## Configuration
- `BIN_TO_BCD_SIGNED_EN` defined:
  - `bin` is two's complement.
  - At capture, `neg`=`bin[N-1]` is latched into a pending-sign register, and the shift register loads the magnitude (−bin when negative, computed as unsigned N bits, so 0x80 → 128).
  - `neg` output updates together with `bcd` at completion.
- Not defined:
  - `bin` is unsigned.
  - `neg` is tied to 0.
  - The magnitude/sign logic is absent.

## Structure
- Package `bcd_pkg` holds:
  - the state enum {IDLE, CONV}
  - the width constant for the iteration counter, $clog2(N+1)
  - the localparam for the digit width, 4
- Sub-module `bcd_add3`: a combinational 4-bit correction cell (in ≥5 → in+3, otherwise in). The top instantiates DIGITS copies via generate.

## Test plan
- Reset, then `start` with `bin`=0 → `done` 8 cycles later, `bcd`=12'h000, `neg`=0; `busy` high for exactly 8 cycles.
- `bin`=255 → `bcd`=12'h255; `bin`=99 → 12'h099; `bin`=100 → 12'h100.
- Back-to-back: `start`=1 with 37, then `start`=1 with 200 in the `done` cycle → first result 12'h037, second result 12'h200 exactly 9 cycles after the first `done`.
- `start` with 42, then `start` with 7 pulsed mid-conversion → single `done`, `bcd`=12'h042; the second request is ignored.
- `start` with 255, `reset` asserted 3 cycles later → no `done`; `bcd`=0 and `busy`=0 after the reset edge.
- With `BIN_TO_BCD_SIGNED_EN`:
  - 0x80 → `neg`=1, `bcd`=12'h128
  - 0xFF → `neg`=1, 12'h001
  - 0x7F → `neg`=0, 12'h127
